// File: rtl/mult_dot_seq.sv
// Feeds operand pairs to an external start/busy multiplier and sums the products into a dot product.
// Latency is 11 cycles per pair against an 8-cycle multiplier; no operand buffering; result held until res_ready_i.
module mult_dot_seq #(
  parameter int ACC_W = 24
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             op_valid_i,
  output logic             op_ready_o,
  input  logic [7:0]       op_a_bi,
  input  logic [7:0]       op_b_bi,
  input  logic             op_last_i,
  output logic             mult_start_o,
  output logic [7:0]       mult_a_bo,
  output logic [7:0]       mult_b_bo,
  input  logic             mult_busy_i,
  input  logic [15:0]      mult_y_bi,
  output logic             res_valid_o,
  input  logic             res_ready_i,
  output logic [ACC_W-1:0] res_bo,
  output logic [7:0]       res_cnt_bo,
  output logic             ovf_o
);

  typedef enum logic [2:0] {
    IDLE,
    START,
    WAIT_RISE,
    WAIT_FALL,
    OUT
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [7:0]       a_q;
  logic [7:0]       b_q;
  logic             last_q;
  logic [ACC_W-1:0] acc;
  logic [7:0]       cnt;
  logic             ovf;
  logic [ACC_W:0]   sum;
  logic             accept;
  logic             accum;
  logic             clear;

  // One extra bit on the adder so the carry-out can set the sticky overflow.
  assign sum    = {1'b0, acc} + {{(ACC_W - 15){1'b0}}, mult_y_bi};
  assign accept = op_valid_i && op_ready_o;
  assign accum  = (state == WAIT_FALL) && !mult_busy_i;
  assign clear  = (state == OUT) && res_ready_i;

  always_comb begin
    state_nxt    = state;
    op_ready_o   = 1'b0;
    mult_start_o = 1'b0;
    res_valid_o  = 1'b0;
    case (state)
      IDLE: begin
        op_ready_o = 1'b1;
        if (op_valid_i) state_nxt = START;
      end
      START: begin
        // A multiply left over from before a reset must drain before we start ours.
        if (!mult_busy_i) begin
          mult_start_o = 1'b1;
          state_nxt    = WAIT_RISE;
        end
      end
      WAIT_RISE: begin
        if (mult_busy_i) state_nxt = WAIT_FALL;
      end
      WAIT_FALL: begin
        if (!mult_busy_i) state_nxt = last_q ? OUT : IDLE;
      end
      OUT: begin
        res_valid_o = 1'b1;
        if (res_ready_i) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state  <= IDLE;
      a_q    <= '0;
      b_q    <= '0;
      last_q <= 1'b0;
      acc    <= '0;
      cnt    <= '0;
      ovf    <= 1'b0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        a_q    <= op_a_bi;
        b_q    <= op_b_bi;
        last_q <= op_last_i;
      end
      if (accum) begin
        acc <= sum[ACC_W-1:0];
        cnt <= cnt + 8'd1;
        if (sum[ACC_W]) ovf <= 1'b1;
      end else if (clear) begin
        acc <= '0;
        cnt <= '0;
        ovf <= 1'b0;
      end
    end
  end

  assign mult_a_bo  = a_q;
  assign mult_b_bo  = b_q;
  assign res_bo     = acc;
  assign res_cnt_bo = cnt;
  assign ovf_o      = ovf;

endmodule

// File: tb/tb_mult_dot_seq.sv
// Directed bench: 24-bit and 16-bit instances share one behavioural 8-cycle multiplier.
module tb_mult_dot_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        op_valid;
  logic [7:0]  op_a;
  logic [7:0]  op_b;
  logic        op_last;
  logic        res_ready;
  logic        mult_busy;
  logic [15:0] mult_y = '0;

  logic        op_ready, mult_start, res_valid, ovf;
  logic [7:0]  mult_a, mult_b, res_cnt;
  logic [23:0] res;

  logic        op_ready16, mult_start16, res_valid16, ovf16;
  logic [7:0]  mult_a16, mult_b16, res_cnt16;
  logic [15:0] res16;

  always #5 clk = ~clk;

  mult_dot_seq #(.ACC_W(24)) dut (
    .clk_i(clk), .rst_i(rst),
    .op_valid_i(op_valid), .op_ready_o(op_ready),
    .op_a_bi(op_a), .op_b_bi(op_b), .op_last_i(op_last),
    .mult_start_o(mult_start), .mult_a_bo(mult_a), .mult_b_bo(mult_b),
    .mult_busy_i(mult_busy), .mult_y_bi(mult_y),
    .res_valid_o(res_valid), .res_ready_i(res_ready),
    .res_bo(res), .res_cnt_bo(res_cnt), .ovf_o(ovf)
  );

  mult_dot_seq #(.ACC_W(16)) dut16 (
    .clk_i(clk), .rst_i(rst),
    .op_valid_i(op_valid), .op_ready_o(op_ready16),
    .op_a_bi(op_a), .op_b_bi(op_b), .op_last_i(op_last),
    .mult_start_o(mult_start16), .mult_a_bo(mult_a16), .mult_b_bo(mult_b16),
    .mult_busy_i(mult_busy), .mult_y_bi(mult_y),
    .res_valid_o(res_valid16), .res_ready_i(res_ready),
    .res_bo(res16), .res_cnt_bo(res_cnt16), .ovf_o(ovf16)
  );

  // Multiplier model: busy for 8 cycles after the start edge, product presented as busy falls.
  // It is deliberately not reset, so a multiply in flight survives a sequencer reset.
  logic       m_busy = 1'b0;
  logic       ext_busy = 1'b0;
  int         m_left = 0;
  logic [7:0] m_a = '0;
  logic [7:0] m_b = '0;

  assign mult_busy = m_busy | ext_busy;

  always @(posedge clk) begin
    if (m_busy) begin
      if (m_left == 1) begin
        m_busy <= 1'b0;
        mult_y <= 16'(m_a) * 16'(m_b);
      end
      m_left <= m_left - 1;
    end else if (mult_start) begin
      m_busy <= 1'b1;
      m_left <= 8;
      m_a    <= mult_a;
      m_b    <= mult_b;
    end
  end

  int   cyc = 0;
  int   starts = 0;
  int   dbl = 0;
  logic start_d = 1'b0;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (mult_start) starts <= starts + 1;
    if (mult_start && start_d) dbl <= dbl + 1;
    start_d <= mult_start;
  end

  int errors = 0;
  int checks = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Present a pair and return the cycle number of the edge that accepted it; op_valid stays high.
  task automatic send(input logic [7:0] a, input logic [7:0] b, input logic last, output int at);
    int n;
    n = 0;
    @(negedge clk);
    op_a = a; op_b = b; op_last = last; op_valid = 1'b1;
    while (!op_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("send_ready", op_ready, 1);
    @(posedge clk);
    #1;
    at = cyc;
  endtask

  task automatic wait_res(output int at);
    int n;
    n = 0;
    while (!res_valid && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("res_valid_seen", res_valid, 1);
    at = cyc;
  endtask

  task automatic accept_res();
    @(negedge clk);
    res_ready = 1'b1;
    op_valid  = 1'b0;
    @(posedge clk);
    #1;
    res_ready = 1'b0;
    chk("accept_idle", op_ready, 1);
    chk("accept_clr", res, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int t0, t1, t2, s0, bad;
    rst = 1'b1; op_valid = 1'b0; op_a = '0; op_b = '0; op_last = 1'b0; res_ready = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    chk("rst_op_ready", op_ready, 1);
    chk("rst_start", mult_start, 0);
    chk("rst_res_valid", res_valid, 0);
    chk("rst_res", res, 0);
    chk("rst_cnt", res_cnt, 0);
    chk("rst_ovf", ovf, 0);
    chk("rst_mult_a", mult_a, 0);
    chk("rst_mult_b", mult_b, 0);
    rst = 1'b0;

    // Single pair 255*255; valid is visible from the 10th edge after the accept edge.
    s0 = starts;
    send(8'hFF, 8'hFF, 1'b1, t0);
    op_valid = 1'b0;
    wait_res(t1);
    chk("t1_latency", t1 - t0, 10);
    chk("t1_res", res, 24'h00FE01);
    chk("t1_cnt", res_cnt, 1);
    chk("t1_ovf", ovf, 0);
    chk("t1_starts", starts - s0, 1);
    accept_res();
    chk("t1_cnt_clr", res_cnt, 0);

    // Back-to-back vector (3,4),(5,6),(7,8): 12+30+56 = 98.
    res_ready = 1'b1;
    s0 = starts;
    send(8'd3, 8'd4, 1'b0, t0);
    send(8'd5, 8'd6, 1'b0, t1);
    chk("t2_gap1", t1 - t0, 11);
    send(8'd7, 8'd8, 1'b1, t2);
    chk("t2_gap2", t2 - t1, 11);
    op_valid = 1'b0;
    wait_res(t0);
    chk("t2_res", res, 98);
    chk("t2_cnt", res_cnt, 3);
    chk("t2_ovf", ovf, 0);
    @(posedge clk);
    #1;
    chk("t2_valid_drop", res_valid, 0);
    chk("t2_op_ready", op_ready, 1);
    chk("t2_res_clr", res, 0);
    chk("t2_starts", starts - s0, 3);
    chk("t2_single_pulse", dbl, 0);
    res_ready = 1'b0;

    // Overflow on the 16-bit instance: 2*0xFE01 = 0x1FC02.
    send(8'hFF, 8'hFF, 1'b0, t0);
    send(8'hFF, 8'hFF, 1'b1, t0);
    op_valid = 1'b0;
    wait_res(t0);
    chk("t3_res16", res16, 16'hFC02);
    chk("t3_ovf16", ovf16, 1);
    chk("t3_valid16", res_valid16, 1);
    chk("t3_cnt16", res_cnt16, 2);
    chk("t3_res24", res, 24'h01FC02);
    chk("t3_ovf24", ovf, 0);
    accept_res();
    send(8'd1, 8'd1, 1'b1, t0);
    op_valid = 1'b0;
    wait_res(t0);
    chk("t3b_res16", res16, 1);
    chk("t3b_ovf16", ovf16, 0);
    accept_res();

    // Result backpressure with op_valid held and different operands offered.
    s0 = starts;
    send(8'd2, 8'd3, 1'b1, t0);
    op_a = 8'd9; op_b = 8'd9; op_last = 1'b0;
    wait_res(t0);
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      if (!res_valid || res != 24'd6 || res_cnt != 8'd1 || op_ready || mult_a != 8'd2) bad++;
    end
    chk("t4_stable", bad, 0);
    chk("t4_starts", starts - s0, 1);
    accept_res();
    chk("t4_valid_drop", res_valid, 0);
    chk("t4_cnt_clr", res_cnt, 0);

    // Multiplier still busy when the pair arrives: hold in START without a pulse.
    ext_busy = 1'b1;
    s0 = starts;
    send(8'd6, 8'd7, 1'b1, t0);
    op_valid = 1'b0;
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      if (mult_start) bad++;
    end
    chk("t5_no_start", bad, 0);
    chk("t5_held", op_ready, 0);
    ext_busy = 1'b0;
    #1;
    chk("t5_start_release", mult_start, 1);
    wait_res(t0);
    chk("t5_res", res, 42);
    chk("t5_cnt", res_cnt, 1);
    chk("t5_starts", starts - s0, 1);
    chk("t5_single_pulse", dbl, 0);
    accept_res();

    // Reset while the second pair of a vector is in WAIT_FALL.
    send(8'd3, 8'd4, 1'b0, t0);
    send(8'd1, 8'd5, 1'b0, t0);
    op_valid = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    chk("t6_busy_before", mult_busy, 1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("t6_op_ready", op_ready, 1);
    chk("t6_res_valid", res_valid, 0);
    chk("t6_res", res, 0);
    chk("t6_cnt", res_cnt, 0);
    chk("t6_ovf", ovf, 0);
    chk("t6_start", mult_start, 0);
    chk("t6_mult_a", mult_a, 0);
    chk("t6_mult_b", mult_b, 0);
    send(8'd2, 8'd2, 1'b1, t0);
    op_valid = 1'b0;
    wait_res(t0);
    chk("t6_res_after", res, 4);
    chk("t6_cnt_after", res_cnt, 1);
    accept_res();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
